// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Debug read-initiator for the CPU register file. On start it walks register
//   indices FIRST_REG..LAST_REG through a spare combinational read port, puts
//   each word on a valid/ready stream tagged with its index, keeps a running
//   XOR checksum of everything dumped, and pulses done when the walk completes.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-high
//   start      begin a dump (sampled only in IDLE)
//   abort      synchronous cancel back to IDLE, highest priority
//   rd_addr    registered index to the register-file read port
//   rd_data    combinational read data for rd_addr
//   out_valid  out_index/out_data hold a word
//   out_ready  consumer accepts on out_valid && out_ready at clk edge
//   out_index  index of presented word
//   out_data   presented word
//   busy       high in READ and SEND
//   done       one-cycle pulse after the last word is accepted
//   checksum   XOR of all words dumped in the current/last run
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam logic [4:0] FIRST  = 5'(FIRST_REG);
  localparam logic [4:0] LAST   = 5'(LAST_REG);
  localparam bit         CFG_OK = (FIRST_REG >= 0) && (LAST_REG <= 31) &&
                                  (LAST_REG >= FIRST_REG);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t state, state_nx;

  logic at_last;
  assign at_last = (rd_addr == LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = READ;
        READ:    state_nx = SEND;
        SEND:    if (out_ready) state_nx = at_last ? DONE : READ;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = (state == READ) || (state == SEND);
  assign done = (state == DONE);

  // ----------------------------------------------------------- datapath
  // In SEND out_valid is always 1, so out_ready alone marks an accept there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      checksum  <= '0;
    end else if (abort) begin
      // Partial checksum and last presented word are kept for inspection.
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rd_addr  <= FIRST;
          checksum <= '0;
        end
        READ: begin
          out_data  <= rd_data;
          out_index <= rd_addr;
          out_valid <= 1'b1;
          checksum  <= checksum ^ rd_data;
        end
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          // Stop at LAST so rd_addr never walks past the range or wraps.
          if (!at_last) rd_addr <= rd_addr + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Illegal parameter combination (empty or out-of-range walk).
  a_cfg: assert property (@(posedge clk) CFG_OK)
    else $error("regfile_dump_reader: illegal FIRST_REG/LAST_REG");

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//   Directed bench: full dump, backpressure, single-register instance,
//   concurrent writes, abort/restart and reset mid-dump.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [4:0]  rd_addr, out_index;
  logic [31:0] rd_data, out_data, checksum;
  logic        out_valid, busy, done;

  logic        start1, out_ready1, abort1;
  logic [4:0]  rd_addr1, out_index1;
  logic [31:0] rd_data1, out_data1, checksum1;
  logic        out_valid1, busy1, done1;

  logic [31:0] regs [32];
  logic [31:0] exp_d [32];

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, overlap = 0;
  logic [4:0]  qi [$];
  logic [31:0] qd [$];

  assign rd_data  = (rd_addr  == 5'd0) ? 32'h0 : regs[rd_addr];
  assign rd_data1 = (rd_addr1 == 5'd0) ? 32'h0 : regs[rd_addr1];

  regfile_dump_reader u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum));

  regfile_dump_reader #(.FIRST_REG(7), .LAST_REG(7)) u_one (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_index(out_index1), .out_data(out_data1),
    .busy(busy1), .done(done1), .checksum(checksum1));

  always #5 clk = ~clk;

  // Accepted-word log and done/valid monitors for the main instance.
  always @(posedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready && !abort) begin
        qi.push_back(out_index);
        qd.push_back(out_data);
      end
      if (done) done_cnt = done_cnt + 1;
      if (done && out_valid) overlap = overlap + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload();
    regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 32; i++) exp_d[i] = regs[i];
  endtask

  function automatic logic [31:0] xor_upto(input int last);
    logic [31:0] x = 32'h0;
    for (int i = 0; i <= last; i++) x ^= exp_d[i];
    return x;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk({tag, "_timeout"}, {31'b0, done}, 32'd1);
  endtask

  task automatic wait_valid_idx(input string tag, input logic [4:0] idx);
    int t = 0;
    while (!(out_valid && out_index == idx) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_seen"}, {27'b0, out_index}, {27'b0, idx});
  endtask

  task automatic check_dump(input string tag, input int base);
    int errs = 0;
    chk({tag, "_cnt"}, qi.size() - base, 32);
    for (int i = 0; i < 32 && base + i < qi.size(); i++)
      if (qi[base+i] !== 5'(i) || qd[base+i] !== exp_d[i]) errs++;
    chk({tag, "_order"}, errs, 0);
    chk({tag, "_csum"}, checksum, xor_upto(31));
  endtask

  initial begin
    int c, qb, db;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; out_ready1 = 1'b1; abort1 = 1'b0;
    preload();
    repeat (2) @(negedge clk);
    chk("rst_addr",  {27'b0, rd_addr}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_out",   {27'b0, out_index} | out_data, 0);
    chk("rst_flags", {30'b0, busy, done}, 0);
    chk("rst_csum",  checksum, 0);
    reset = 1'b0;
    @(negedge clk);

    // ---- full dump, out_ready held high
    qb = qi.size(); db = done_cnt;
    pulse_start();
    chk("t1_busy",  {31'b0, busy}, 1);
    chk("t1_v0",    {31'b0, out_valid}, 0);
    @(negedge clk);
    chk("t1_v1",    {31'b0, out_valid}, 1);
    chk("t1_idx0",  {27'b0, out_index}, 0);
    wait_done("t1", c);
    chk("t1_lat",   c + 1, 64);
    @(negedge clk);
    chk("t1_done1", done_cnt - db, 1);
    chk("t1_idle",  {30'b0, busy, done}, 0);
    check_dump("t1", qb);

    // ---- backpressure on index 3
    qb = qi.size(); db = done_cnt;
    pulse_start();
    wait_valid_idx("t2", 5'd2);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_v", {31'b0, out_valid}, 1);
      chk("t2_hold_i", {27'b0, out_index}, 3);
      chk("t2_hold_d", out_data, 32'h1000_0003);
      if (k < 4) @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done("t2", c);
    @(negedge clk);
    chk("t2_done1", done_cnt - db, 1);
    check_dump("t2", qb);

    // ---- single-register instance, FIRST_REG = LAST_REG = 7
    regs[7] = 32'hDEAD_BEEF;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t3_busy", {31'b0, busy1}, 1);
    @(negedge clk);
    chk("t3_v",    {31'b0, out_valid1}, 1);
    chk("t3_idx",  {27'b0, out_index1}, 7);
    chk("t3_data", out_data1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t3_done", {30'b0, done1, out_valid1}, 32'd2);
    chk("t3_csum", checksum1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t3_idle", {30'b0, done1, busy1}, 0);
    chk("t3_addr", {27'b0, rd_addr1}, 7);

    // ---- concurrent writes: r5 on READ-ending edge, r9 ahead of its READ
    preload();
    exp_d[9] = 32'h99;
    qb = qi.size();
    pulse_start();
    c = 0;
    while (!(busy && !out_valid && rd_addr == 5'd5) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t4_read5", {27'b0, rd_addr}, 5);
    @(posedge clk);
    #1;
    regs[5] = 32'h55;
    regs[9] = 32'h99;
    wait_done("t4", c);
    @(negedge clk);
    check_dump("t4", qb);

    // ---- abort while SEND on index 10, restart 2 cycles later
    preload();
    db = done_cnt;
    pulse_start();
    wait_valid_idx("t5", 5'd9);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_idx10", {27'b0, out_index}, 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort", {29'b0, out_valid, busy, done}, 0);
    chk("t5_part",  checksum, xor_upto(10));
    @(negedge clk);
    chk("t5_nodone", done_cnt - db, 0);
    qb = qi.size();
    out_ready = 1'b1;
    pulse_start();
    chk("t5_rs_addr", {27'b0, rd_addr}, 0);
    chk("t5_rs_csum", checksum, 0);
    wait_done("t5", c);
    @(negedge clk);
    check_dump("t5", qb);

    // ---- reset during SEND, then fresh dump with ignored extra start
    pulse_start();
    wait_valid_idx("t6", 5'd3);
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_v",    {30'b0, out_valid, busy}, 0);
    chk("t6_rst_out",  {27'b0, out_index} | out_data | {27'b0, rd_addr}, 0);
    chk("t6_rst_csum", checksum, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    qb = qi.size(); db = done_cnt;
    pulse_start();
    @(negedge clk);
    pulse_start();
    wait_done("t6", c);
    @(negedge clk);
    chk("t6_done1", done_cnt - db, 1);
    check_dump("t6", qb);
    chk("overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
